// File: rtl/data_sampler.sv
// UART RX oversampling sampler: 3-tap majority vote around mid-bit, one strobe per bit period.
// Latency: rx_in reaches rx_s after 2 clk; sampled_bit/sample_valid register one clk after edge_cnt==mid; no backpressure.
module data_sampler (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       rx_in,
    input  logic [5:0] prescale,
    output logic       sampled_bit,
    output logic       sample_valid,
    output logic [4:0] edge_cnt,
    output logic [3:0] bit_cnt
);

    logic       rx_meta;
    logic       rx_s;
    logic [5:0] prescale_q;
    logic [5:0] prescale_legal;
    logic       s0;
    logic       s1;

    logic [5:0] edge_ext;
    logic [5:0] last_edge;
    logic [5:0] mid;
    logic [5:0] mid_m1;
    logic [5:0] mid_m2;
    logic       at_last;
    logic       at_s0;
    logic       at_s1;
    logic       at_mid;
    logic       vote;

    // Line idles high, so both stages reset to 1 to avoid a false start bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_s    <= rx_meta;
        end
    end

    always_comb begin
        prescale_legal = 6'd8;
        case (prescale)
            6'd8, 6'd16, 6'd32: prescale_legal = prescale;
            default:            prescale_legal = 6'd8;
        endcase
    end

    // Ratio is frozen for the whole frame; only an idle cycle can pick up a new value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prescale_q <= 6'd8;
        end else if (!en) begin
            prescale_q <= prescale_legal;
        end
    end

    assign edge_ext  = {1'b0, edge_cnt};
    assign last_edge = prescale_q - 6'd1;
    assign mid       = prescale_q >> 1;
    assign mid_m1    = mid - 6'd1;
    assign mid_m2    = mid - 6'd2;

    assign at_last = (edge_ext == last_edge);
    assign at_s0   = (edge_ext == mid_m2);
    assign at_s1   = (edge_ext == mid_m1);
    assign at_mid  = (edge_ext == mid);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= 5'd0;
            bit_cnt  <= 4'd0;
        end else if (!en) begin
            edge_cnt <= 5'd0;
            bit_cnt  <= 4'd0;
        end else if (at_last) begin
            edge_cnt <= 5'd0;
            bit_cnt  <= bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 5'd1;
        end
    end

    // Taps are cleared to the idle level so an aborted bit cannot leak into the next frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0 <= 1'b1;
            s1 <= 1'b1;
        end else if (!en) begin
            s0 <= 1'b1;
            s1 <= 1'b1;
        end else begin
            if (at_s0) begin
                s0 <= rx_s;
            end
            if (at_s1) begin
                s1 <= rx_s;
            end
        end
    end

    assign vote = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sampled_bit  <= 1'b1;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= en & at_mid;
            if (en && at_mid) begin
                sampled_bit <= vote;
            end
        end
    end

endmodule

// File: doc/data_sampler.md
DATA_SAMPLER -- requirements
Module: data_sampler

Interface
REQ-001 SHALL have the port clk, input, 1 bit: rising-edge clock running at the oversampling rate.
REQ-002 SHALL have the port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have the port en, input, 1 bit: sampling enable from the RX FSM; high while a frame is being received.
REQ-004 SHALL have the port rx_in, input, 1 bit: asynchronous serial line, idle high.
REQ-005 SHALL have the port prescale, input, 6 bits: oversampling ratio; the legal values are 8, 16 and 32.
REQ-006 SHALL have the port sampled_bit, output, 1 bit: majority-voted bit value, registered.
REQ-007 SHALL have the port sample_valid, output, 1 bit: one-cycle strobe that marks a new sampled_bit.
REQ-008 SHALL have the port edge_cnt, output, 5 bits: oversampling edge position within the current bit.
REQ-009 SHALL have the port bit_cnt, output, 4 bits: bit index within the frame, where 0 is the start bit.

Function
REQ-010 SHALL pass rx_in through a 2-flop synchronizer (rx_s), with both flops resetting to 1; all sampling uses rx_s.
REQ-011 SHALL register prescale into prescale_q on every clock edge while en=0 and hold prescale_q while en=1.
REQ-012 SHALL store 8 in prescale_q for any prescale value other than 8, 16 or 32.
REQ-013 SHALL load edge_cnt=0 and bit_cnt=0 on a clock edge where en=0.
REQ-014 SHALL, on a clock edge where en=1, increment edge_cnt, and when edge_cnt==prescale_q-1 instead load edge_cnt=0 and increment bit_cnt.
REQ-015 SHALL wrap bit_cnt from 15 to 0 without saturating.
REQ-016 SHALL define mid=prescale_q/2, giving mid=4, 8 or 16.
REQ-017 SHALL capture rx_s into s0 on the clock edge where en=1 and edge_cnt==mid-2.
REQ-018 SHALL capture rx_s into s1 on the clock edge where en=1 and edge_cnt==mid-1.
REQ-019 SHALL, on the clock edge where en=1 and edge_cnt==mid, load sampled_bit with majority(s0, s1, rx_s) and set sample_valid=1.
REQ-020 SHALL hold sample_valid high only for the cycle in which edge_cnt==mid+1, and low in every other cycle.
REQ-021 SHALL produce exactly one sample_valid pulse per bit period while en=1.
REQ-022 SHALL make sampled_bit hold its value between strobes and across deassertion of en.
REQ-023 SHALL, when en falls mid-bit, clear the counters per REQ-013, clear s0 and s1 to 1, and force sample_valid=0 on the next edge, with no partial sample emitted.
REQ-024 SHALL, when en rises again, restart at edge_cnt=0 using the prescale_q value latched during the preceding en=0 cycle.
REQ-025 SHALL give a prescale change while en=1 no effect until en has been low for at least one clock.
REQ-026 SHALL have a latency from an rx_in transition to its visibility in rx_s of 2 clk.

Reset
REQ-027 SHALL, while rst=0, force sampled_bit=1, sample_valid=0, edge_cnt=0, bit_cnt=0, prescale_q=8, s0=s1=1 and both synchronizer flops=1, independent of clk.
REQ-028 SHALL, when rst is released, begin normal operation on the first subsequent rising clk edge, with no additional internal delay.
REQ-029 SHALL apply REQ-027 even when rst asserts mid-frame, discarding any in-progress sample.

Verification
REQ-030 SHALL be covered by this directed scenario: prescale=8, rx_in=0 for more than 3 clk, then en=1 at cycle 0 -> sample_valid high in cycles 5, 13, 21 with sampled_bit=0, and bit_cnt becomes 1 in cycle 8.
REQ-031 SHALL be covered by this directed scenario: prescale=16, rx_s=0 except rx_s=1 only at edge_cnt=7 -> sampled_bit=0 at edge_cnt=9; then rx_s=1 at edge_cnt 6 and 8 -> sampled_bit=1.
REQ-032 SHALL be covered by this directed scenario: prescale=32, en=1 for a 10-bit frame -> pulses at edge_cnt=17 of each bit, 10 pulses in total, bit_cnt sequences 0..9 and edge_cnt peaks at 31.
REQ-033 SHALL be covered by this directed scenario: prescale=12 (illegal) while idle, then en=1 -> behaves as prescale 8, with the first pulse at cycle 5.
REQ-034 SHALL be covered by this directed scenario: en dropped at edge_cnt=3 (prescale 8), then raised 2 cycles later -> no pulse in between, and the next pulse comes 5 cycles after the rise.
REQ-035 SHALL be covered by this directed scenario: rst asserted at edge_cnt=4 mid-frame -> all outputs immediately at their REQ-027 values, and after release with en=1 the first pulse occurs at edge_cnt=5.
